// File: rtl/gsqrt_gen.sv
// gsqrt_gen: stochastic gradient-descent square-root unit with regenerate mode.
// A saturating up/down counter is compared against an external random number to form the output stream.
module gsqrt_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned INIT  = 1 << (WIDTH - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic [WIDTH-1:0] randNum,
    input  logic             in,
    output logic             out,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] L_INIT = INIT[WIDTH-1:0];

    logic [WIDTH-1:0] r_cnt;
    logic [DEPTH-1:0] r_dly;
    logic             w_out;
    logic             w_out_dly;
    logic             w_inc;
    logic             w_dec;

    assign w_out     = (r_cnt >= randNum);
    assign w_out_dly = r_dly[DEPTH-1];
    assign w_inc     = in;
    // sqrt mode decrements on out AND a decorrelated copy of out, so P(out)^2 tracks P(in)
    assign w_dec     = mode ? w_out : (w_out & w_out_dly);

    assign out   = w_out;
    assign cnt_o = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= L_INIT;
            r_dly <= '0;
        end else if (clr) begin
            r_cnt <= L_INIT;
            r_dly <= '0;
        end else if (en) begin
            if (w_inc && !w_dec && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_inc && w_dec && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_dly[0] <= w_out;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

endmodule
